i2s_tdm_tx_master: RTL
======================

Name: i2s_tdm_tx_master

Overview:
- Parametrised multi-channel serial audio transmitter, successor to the fixed two-channel I2S TX master.
- Supports I2S, left-justified and TDM frame formats with 1..16 channels and configurable slot and data widths.
- Has a one-frame holding buffer, an underrun flag and a frame-start strobe.
- Sits between the audio sample source (valid/ready) and the external DAC/codec pins; the CS4344 power-up sequencer drives en_i.

Parameters:
- MclkDiv, 2: clk_i cycles per MCLK period; even, >=2.
- BclkDiv, 8: clk_i cycles per BCLK period; even, >=2.
- Channels, 2: slots per frame, 1..16. Must be even when Format is 0 or 1.
- SlotWidth, 32: BCLK periods per slot; >= DataWidth.
- DataWidth, 24: sample bits per channel, 8..32.
- Format, 0: 0 = I2S (1-bit delay, FS low for first half of slots); 1 = left-justified (no delay, FS high for first half); 2 = TDM (1-bit delay, FS high for bit position 0 only).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- tx_data_i  in  Channels*DataWidth  one frame; channel n at bits [n*DataWidth +: DataWidth], channel 0 = LSBs.
- tx_valid_i  in  1  frame valid.
- tx_ready_o  out  1  holding buffer empty.
- en_i  in  1  serial clocks/output enable.
- i2s_mclk_o  out  1  master clock.
- i2s_bclk_o  out  1  bit clock.
- i2s_fs_o  out  1  frame sync / LRCK.
- i2s_sdat_o  out  1  serial data.
- frame_start_o  out  1  one-cycle pulse when bit position 0 begins.
- underrun_o  out  1  one-cycle pulse when a frame starts with no buffered data.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk_i, rst_i). While rst_i = 1, every output is 0, the holding buffer is empty, all counters are 0 and running is 0. The first cycle after rst_i deasserts, tx_ready_o = 1. A reset mid-frame abandons the frame; outputs are 0 on the next edge.
- All outputs are registered.
- MCLK: counter 0..MclkDiv-1 runs only while en_i = 1. i2s_mclk_o = 1 when counter < MclkDiv/2. With en_i = 0 the counter is held at 0 and the output is 0.
- BCLK counter: bc runs 0..BclkDiv-1 while running = 1. i2s_bclk_o = 1 when bc >= BclkDiv/2, so outputs change on the BCLK falling edge. bit_tick = (bc == BclkDiv-1).
- Position counter: pos runs 0..Channels*SlotWidth-1 and advances on bit_tick, wrapping to 0.
- Load event L: (en_i & !running) OR (bit_tick & pos == last). On L:
  - if the holding buffer is full: holding -> active, buffer marked empty;
  - otherwise: active <= all zeros and underrun_o pulses.
- Position 0 outputs and frame_start_o appear on the cycle after L.
- Handshake:
  - accept when tx_valid_i & tx_ready_o;
  - tx_ready_o = !full, registered, so ready falls the cycle after accept;
  - no bypass: on an accept coinciding with an underrun L, the new frame goes to the holding buffer and the active frame stays zero;
  - tx_data_i is sampled only on accept.
- Stream bit s(p), for p = slot*SlotWidth + k:
  - k < DataWidth: active channel[slot] bit DataWidth-1-k (MSB first);
  - else 0.
- i2s_sdat_o:
  - Format 1: s(pos).
  - Formats 0 and 2: s(pos-1). At pos = 0, output the last stream bit of the previous active frame (0 after reset or disable).
- i2s_fs_o:
  - Format 0: 1 when pos >= Channels*SlotWidth/2.
  - Format 1: 1 when pos < Channels*SlotWidth/2.
  - Format 2: 1 only when pos = 0.
- en_i falling: running <= 0 on the next cycle; bc and pos clear to 0; BCLK/FS/SDAT/MCLK outputs go 0. The holding buffer keeps its contents and still accepts data. No underrun pulses while disabled.
- Frame rate: clk_i / (BclkDiv*Channels*SlotWidth). Defaults give 512 clk_i per frame.

Test Plan:
- Defaults, accept L=0xABCDEF, R=0x123456 before en_i rises:
  - sample SDAT at BCLK rise;
  - positions 1..24 carry 0xABCDEF MSB-first, 25..32 are 0, positions 33..56 carry 0x123456;
  - FS = 0 for positions 0..31 and 1 for 32..63;
  - frame_start_o pulses every 512 cycles.
- Defaults, en_i = 1, no valid: SDAT stays 0, underrun_o pulses exactly once per 512 cycles, tx_ready_o stays 1.
- Back-to-back frames with tx_valid_i held high:
  - first accepted, ready low one cycle later;
  - second accepted only after the next L, ready returning the cycle after L;
  - no underrun.
- Format=1, Channels=2, DataWidth=16, SlotWidth=16, L=0x8001: SDAT = 1 at position 0 and 1 at position 15; FS high for positions 0..15.
- Format=2, Channels=8, SlotWidth=32, DataWidth=16:
  - FS high for exactly BclkDiv cycles per 256-bit frame;
  - channel 5 = 0xA5A5 appears at positions 161..176.
- Reset mid-frame (rst_i high at position 20 for 1 cycle): all outputs 0 the next cycle, tx_ready_o = 1 the cycle after release, holding buffer empty.

Source files
------------

// File: rtl/i2s_tdm_tx_master.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx_master
//
// Multi-channel serial audio transmitter (I2S, left-justified or TDM).
// A one-frame holding buffer accepts samples from the upstream source.
// Each frame boundary moves the buffered frame into the active shift
// position. If nothing is buffered at that point, the active frame is
// zero and an underrun pulse is raised.
//
// Parameters:
//   MclkDiv   - clk_i cycles per MCLK period (even, >= 2)
//   BclkDiv   - clk_i cycles per BCLK period (even, >= 2)
//   Channels  - slots per frame, 1..16 (even for Format 0/1)
//   SlotWidth - BCLK periods per slot (>= DataWidth)
//   DataWidth - sample bits per channel, 8..32
//   Format    - 0 = I2S, 1 = left-justified, 2 = TDM
//
// Ports:
//   clk_i, rst_i   - system clock, synchronous active-high reset
//   tx_data_i      - one frame, channel n at [n*DataWidth +: DataWidth]
//   tx_valid_i     - frame valid
//   tx_ready_o     - holding buffer empty
//   en_i           - serial clock / output enable
//   i2s_mclk_o     - master clock
//   i2s_bclk_o     - bit clock
//   i2s_fs_o       - frame sync / LRCK
//   i2s_sdat_o     - serial data, MSB first
//   frame_start_o  - one-cycle pulse as bit position 0 begins
//   underrun_o     - one-cycle pulse when a frame starts with no data
// ---------------------------------------------------------------------------
module i2s_tdm_tx_master #(
    parameter int MclkDiv   = 2,
    parameter int BclkDiv   = 8,
    parameter int Channels  = 2,
    parameter int SlotWidth = 32,
    parameter int DataWidth = 24,
    parameter int Format    = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [Channels*DataWidth-1:0] tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    input  logic                          en_i,
    output logic                          i2s_mclk_o,
    output logic                          i2s_bclk_o,
    output logic                          i2s_fs_o,
    output logic                          i2s_sdat_o,
    output logic                          frame_start_o,
    output logic                          underrun_o
);

    localparam int FrameW = Channels * DataWidth;
    localparam int McW    = $clog2(MclkDiv);
    localparam int BcW    = $clog2(BclkDiv);
    localparam int SlotW  = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int KW     = (SlotWidth > 1) ? $clog2(SlotWidth) : 1;

    localparam logic [McW-1:0]   McLast   = McW'(MclkDiv - 1);
    localparam logic [McW-1:0]   McHalf   = McW'(MclkDiv / 2);
    localparam logic [BcW-1:0]   BcLast   = BcW'(BclkDiv - 1);
    localparam logic [BcW-1:0]   BcHalf   = BcW'(BclkDiv / 2);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(Channels - 1);
    localparam logic [SlotW-1:0] SlotHalf = SlotW'(Channels / 2);
    localparam logic [KW-1:0]    KLast    = KW'(SlotWidth - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [McW-1:0]    mc, mc_n;
    logic [BcW-1:0]    bc, bc_n;
    logic [SlotW-1:0]  slot, slot_n;
    logic [KW-1:0]     k, k_n;
    logic [FrameW-1:0] holding;
    logic [FrameW-1:0] active, active_n;
    logic              full, full_n;
    logic              accept, bit_tick, frame_end, load;
    logic              sdat_n, fs_n;

    // The bit position is tracked as (slot, bit-within-slot) so that no
    // division is needed to locate a channel. Bits past DataWidth in a
    // slot are padding and read as zero.
    function automatic logic stream_bit(input logic [FrameW-1:0] frame,
                                        input logic [SlotW-1:0]  slot_idx,
                                        input logic [KW-1:0]     bit_idx);
        logic [FrameW-1:0] shifted;
        shifted = '0;
        if (int'(bit_idx) < DataWidth) begin
            shifted = frame >> (int'(slot_idx) * DataWidth + DataWidth - 1 - int'(bit_idx));
        end
        return shifted[0];
    endfunction

    always_comb begin
        accept    = tx_valid_i & tx_ready_o;
        bit_tick  = (state == ST_RUN) && (bc == BcLast);
        frame_end = bit_tick && (slot == SlotLast) && (k == KLast);
        // A frame is loaded when the serial engine starts and at every wrap.
        load      = en_i && ((state == ST_IDLE) || frame_end);

        mc_n = '0;
        if (en_i) begin
            mc_n = (mc == McLast) ? '0 : mc + 1'b1;
        end

        state_n = state;
        bc_n    = bc;
        slot_n  = slot;
        k_n     = k;
        if (!en_i) begin
            state_n = ST_IDLE;
            bc_n    = '0;
            slot_n  = '0;
            k_n     = '0;
        end else if (load) begin
            state_n = ST_RUN;
            bc_n    = '0;
            slot_n  = '0;
            k_n     = '0;
        end else if (bit_tick) begin
            bc_n = '0;
            if (k == KLast) begin
                k_n    = '0;
                slot_n = slot + 1'b1;
            end else begin
                k_n = k + 1'b1;
            end
        end else begin
            bc_n = bc + 1'b1;
        end

        active_n = active;
        if (load) begin
            active_n = full ? holding : '0;
        end

        // An accept can only happen while empty, so it never collides with
        // a buffer-to-active transfer; no bypass into the active frame.
        full_n = full;
        if (load && full) begin
            full_n = 1'b0;
        end else if (accept) begin
            full_n = 1'b1;
        end

        // Delayed formats emit the bit of the position just finished, which
        // at a wrap is the last bit of the outgoing frame. A fresh start has
        // no previous frame and emits zero.
        sdat_n = 1'b0;
        if (en_i) begin
            if (Format == 1) begin
                sdat_n = stream_bit(active_n, slot_n, k_n);
            end else if (state == ST_RUN) begin
                sdat_n = bit_tick ? stream_bit(active, slot, k) : i2s_sdat_o;
            end
        end

        fs_n = 1'b0;
        if (en_i) begin
            case (Format)
                0:       fs_n = (slot_n >= SlotHalf);
                1:       fs_n = (slot_n < SlotHalf);
                default: fs_n = (slot_n == '0) && (k_n == '0);
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            mc            <= '0;
            bc            <= '0;
            slot          <= '0;
            k             <= '0;
            holding       <= '0;
            active        <= '0;
            full          <= 1'b0;
            tx_ready_o    <= 1'b0;
            i2s_mclk_o    <= 1'b0;
            i2s_bclk_o    <= 1'b0;
            i2s_fs_o      <= 1'b0;
            i2s_sdat_o    <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            state         <= state_n;
            mc            <= mc_n;
            bc            <= bc_n;
            slot          <= slot_n;
            k             <= k_n;
            active        <= active_n;
            full          <= full_n;
            if (accept) begin
                holding <= tx_data_i;
            end
            tx_ready_o    <= !full_n;
            i2s_mclk_o    <= en_i && (mc_n < McHalf);
            i2s_bclk_o    <= en_i && (bc_n >= BcHalf);
            i2s_fs_o      <= fs_n;
            i2s_sdat_o    <= sdat_n;
            frame_start_o <= load;
            underrun_o    <= load && !full;
        end
    end

endmodule
